// File: rtl/id_ex_alu_stage.sv
// id_ex_alu_stage: ID/EX register with ALU control decode and operand select.
// Define FORWARDING_EN to enable EX/MEM and MEM/WB operand forwarding.
module id_ex_alu_stage #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  stall_i,
    input  logic                  flush_i,
    input  logic                  valid_i,
    input  logic [DATA_W-1:0]     rs1_data_i,
    input  logic [DATA_W-1:0]     rs2_data_i,
    input  logic [DATA_W-1:0]     imm_i,
    input  logic [REG_ADDR_W-1:0] rs1_addr_i,
    input  logic [REG_ADDR_W-1:0] rs2_addr_i,
    input  logic [REG_ADDR_W-1:0] rd_addr_i,
    input  logic [9:0]            funct_i,
    input  logic [1:0]            alu_op_i,
    input  logic                  alu_src_i,
    input  logic                  reg_write_i,
    input  logic                  mem_to_reg_i,
    input  logic                  mem_read_i,
    input  logic                  mem_write_i,
    input  logic [REG_ADDR_W-1:0] exmem_rd_i,
    input  logic                  exmem_reg_write_i,
    input  logic [DATA_W-1:0]     exmem_data_i,
    input  logic [REG_ADDR_W-1:0] memwb_rd_i,
    input  logic                  memwb_reg_write_i,
    input  logic [DATA_W-1:0]     memwb_data_i,
    output logic [DATA_W-1:0]     src1_o,
    output logic [DATA_W-1:0]     src2_o,
    output logic [2:0]            alu_ctr_o,
    output logic [DATA_W-1:0]     mem_wdata_o,
    output logic [REG_ADDR_W-1:0] rd_addr_o,
    output logic                  valid_o,
    output logic                  reg_write_o,
    output logic                  mem_to_reg_o,
    output logic                  mem_read_o,
    output logic                  mem_write_o,
    output logic                  illegal_o
);
    typedef struct packed {
        logic                  valid;
        logic                  reg_write;
        logic                  mem_to_reg;
        logic                  mem_read;
        logic                  mem_write;
        logic                  illegal;
        logic                  alu_src;
        logic [2:0]            alu_ctr;
        logic [REG_ADDR_W-1:0] rs1_addr;
        logic [REG_ADDR_W-1:0] rs2_addr;
        logic [REG_ADDR_W-1:0] rd_addr;
        logic [DATA_W-1:0]     rs1_data;
        logic [DATA_W-1:0]     rs2_data;
        logic [DATA_W-1:0]     imm;
    } stage_t;

    stage_t     st_d, st_q;
    logic [2:0] ctr;
    logic       ill;
    logic [DATA_W-1:0] fwd_a, fwd_b;

    // Undecodable combinations still drive ADD so the ALU sees a benign op.
    always_comb begin
        ctr = 3'b011;
        ill = 1'b0;
        case (alu_op_i)
            2'b10: case (funct_i)
                10'b0000000_111: ctr = 3'b000;
                10'b0000000_100: ctr = 3'b001;
                10'b0000000_001: ctr = 3'b010;
                10'b0000000_000: ctr = 3'b011;
                10'b0100000_000: ctr = 3'b100;
                10'b0000001_000: ctr = 3'b101;
                default:         ill = 1'b1;
            endcase
            2'b00: begin
                if (funct_i[2:0] == 3'b000) ctr = 3'b110;
                else if (funct_i == 10'b0100000_101) ctr = 3'b111;
                else ill = 1'b1;
            end
            2'b01:   ctr = 3'b011;
            default: ill = 1'b1;
        endcase
    end

    always_comb begin
        st_d            = '0;
        st_d.valid      = valid_i;
        st_d.reg_write  = valid_i & reg_write_i;
        st_d.mem_to_reg = valid_i & mem_to_reg_i;
        st_d.mem_read   = valid_i & mem_read_i;
        st_d.mem_write  = valid_i & mem_write_i;
        st_d.illegal    = valid_i & ill;
        st_d.alu_src    = alu_src_i;
        st_d.alu_ctr    = ctr;
        st_d.rs1_addr   = rs1_addr_i;
        st_d.rs2_addr   = rs2_addr_i;
        st_d.rd_addr    = rd_addr_i;
        st_d.rs1_data   = rs1_data_i;
        st_d.rs2_data   = rs2_data_i;
        st_d.imm        = imm_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) st_q <= '0;
        else if (!stall_i) st_q <= st_d;
    end

`ifdef FORWARDING_EN
    function automatic logic [DATA_W-1:0] fwd(
        input logic                  v,
        input logic [REG_ADDR_W-1:0] a,
        input logic [DATA_W-1:0]     r,
        input logic                  ex_we,
        input logic [REG_ADDR_W-1:0] ex_rd,
        input logic [DATA_W-1:0]     ex_d,
        input logic                  wb_we,
        input logic [REG_ADDR_W-1:0] wb_rd,
        input logic [DATA_W-1:0]     wb_d
    );
        return (v && a != '0 && ex_we && ex_rd == a) ? ex_d :
               (v && a != '0 && wb_we && wb_rd == a) ? wb_d : r;
    endfunction

    assign fwd_a = fwd(st_q.valid, st_q.rs1_addr, st_q.rs1_data, exmem_reg_write_i, exmem_rd_i,
                       exmem_data_i, memwb_reg_write_i, memwb_rd_i, memwb_data_i);
    assign fwd_b = fwd(st_q.valid, st_q.rs2_addr, st_q.rs2_data, exmem_reg_write_i, exmem_rd_i,
                       exmem_data_i, memwb_reg_write_i, memwb_rd_i, memwb_data_i);
`else
    logic unused_fwd;
    assign unused_fwd = ^{exmem_rd_i, exmem_reg_write_i, exmem_data_i, memwb_rd_i,
                          memwb_reg_write_i, memwb_data_i, st_q.rs1_addr, st_q.rs2_addr};
    assign fwd_a = st_q.rs1_data;
    assign fwd_b = st_q.rs2_data;
`endif

    assign src1_o       = fwd_a;
    assign src2_o       = st_q.alu_src ? st_q.imm : fwd_b;
    assign mem_wdata_o  = fwd_b;
    assign alu_ctr_o    = st_q.alu_ctr;
    assign rd_addr_o    = st_q.rd_addr;
    assign valid_o      = st_q.valid;
    assign reg_write_o  = st_q.reg_write;
    assign mem_to_reg_o = st_q.mem_to_reg;
    assign mem_read_o   = st_q.mem_read;
    assign mem_write_o  = st_q.mem_write;
    assign illegal_o    = st_q.illegal;
endmodule
